// File: rtl/sv_dma_sequencer.sv
// sv_dma_sequencer
//   Block-copy engine for the shared WRAM/VRAM byte bus. Holds the CPU-visible
//   DMA register file (offsets 0-5) and, once started, copies length*16 bytes
//   from src to dst with one read cycle, one capture cycle and one write cycle
//   per byte. Every bus phase waits for the grant (rdy). When the job finishes,
//   the sequencer raises a level IRQ.
//
//   State   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | bus released, register file writable, waiting for start
//   S_RD    | present src_cnt on the bus (memory registers the byte)
//   S_CAP   | keep src_cnt on the bus, latch bus_din into data
//   S_WR    | write data to dst_cnt, advance counters
//   S_DONE  | one-cycle wrap-up: busy already low, irq set at exit
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   reg_cs/we/addr/din register-file write port (writes only in S_IDLE)
//   reg_dout          combinational read data for reg_addr
//   rdy               bus grant; all non-idle states hold while low
//   bus_din           memory read data (1-cycle registered latency)
//   bus_addr/dout/we  shared bus drive, zero whenever not transferring
//   busy              sequencer owns the bus
//   irq, irq_ack      completion interrupt and its clear pulse
//
// The register map splits the counters into lo/hi bytes, so ADDR_W must be
// between 9 and 16.
module sv_dma_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_cs,
  input  logic              reg_we,
  input  logic [2:0]        reg_addr,
  input  logic [7:0]        reg_din,
  output logic [7:0]        reg_dout,
  input  logic              rdy,
  input  logic [7:0]        bus_din,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_dout,
  output logic              bus_we,
  output logic              busy,
  output logic              irq,
  input  logic              irq_ack
);

  // length=0 means 256 units, so one extra bit above the 8-bit length field
  localparam int CNT_W = 9 + BLOCK_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_cnt, dst_cnt;
  logic [7:0]        length;
  logic [7:0]        data;
  logic [CNT_W-1:0]  byte_cnt;
  logic [CNT_W-1:0]  load_cnt;
  logic              ctrl_start;
  logic              irq_q;
  logic              reg_wr;
  logic              start;
  logic              last_byte;
  logic              wr_step;

  assign reg_wr    = reg_cs & reg_we & (state == S_IDLE);
  assign start     = reg_wr & (reg_addr == 3'd5) & reg_din[7];
  assign last_byte = (byte_cnt == CNT_W'(1));
  assign wr_step   = (state == S_WR) & rdy;
  assign load_cnt  = (length == 8'd0) ? (CNT_W'(256) << BLOCK_SHIFT)
                                      : (CNT_W'(length) << BLOCK_SHIFT);

  // The stored start bit is exactly the ownership flag: set on start,
  // cleared as the last byte is written, so DONE already reads busy=0.
  assign busy = ctrl_start;
  assign irq  = irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_addr  = '0;
    bus_dout  = 8'h00;
    bus_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RD;
      end
      S_RD: begin
        bus_addr = src_cnt;
        if (rdy) state_nxt = S_CAP;
      end
      S_CAP: begin
        bus_addr = src_cnt;
        if (rdy) state_nxt = S_WR;
      end
      S_WR: begin
        bus_addr = dst_cnt;
        bus_dout = data;
        bus_we   = rdy;
        if (rdy) state_nxt = last_byte ? S_DONE : S_RD;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_cnt    <= '0;
      dst_cnt    <= '0;
      length     <= 8'h00;
      data       <= 8'h00;
      byte_cnt   <= '0;
      ctrl_start <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (reg_addr)
          3'd0: src_cnt[7:0]        <= reg_din;
          3'd1: src_cnt[ADDR_W-1:8] <= reg_din[ADDR_W-9:0];
          3'd2: dst_cnt[7:0]        <= reg_din;
          3'd3: dst_cnt[ADDR_W-1:8] <= reg_din[ADDR_W-9:0];
          3'd4: length              <= reg_din;
          3'd5: begin
            if (reg_din[7]) begin
              ctrl_start <= 1'b1;
              byte_cnt   <= load_cnt;
            end
          end
          default: ;
        endcase
      end

      if ((state == S_CAP) && rdy) data <= bus_din;

      if (wr_step) begin
        src_cnt  <= src_cnt + 1'b1;
        dst_cnt  <= dst_cnt + 1'b1;
        byte_cnt <= byte_cnt - 1'b1;
        if (last_byte) ctrl_start <= 1'b0;
      end

      // A completion landing on the same cycle as an ack must not be lost.
      if (state == S_DONE) begin
        irq_q <= 1'b1;
      end else if (irq_ack) begin
        irq_q <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_dout = 8'hFF;
    case (reg_addr)
      3'd0: reg_dout = src_cnt[7:0];
      3'd1: reg_dout = 8'(src_cnt >> 8);
      3'd2: reg_dout = dst_cnt[7:0];
      3'd3: reg_dout = 8'(dst_cnt >> 8);
      3'd4: reg_dout = length;
      3'd5: reg_dout = {busy, 7'b0};
      default: reg_dout = 8'hFF;
    endcase
  end

endmodule

// File: doc/sv_dma_sequencer.md
Name: sv_dma_sequencer

Overview:
- Sequences the shared WRAM/VRAM byte bus for block copies.
- Holds the CPU-visible DMA register file at 0x2008–0x200D, presented here as offsets 0–5.
- Copies length×16 bytes from source to destination, one byte at a time, by read-then-write bus cycles.
- Stalls on the bus-grant input, asserts busy so the top level can steer the shared bus and halt the CPU, and raises an IRQ on completion.

Parameters:
- ADDR_W, 16, width of the source/destination address counters and of bus_addr.
- BLOCK_SHIFT, 4, log2 of the bytes transferred per length unit (16 bytes).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reg_cs  in  1  register-file select from the address decode
- reg_we  in  1  register write strobe; valid only while reg_cs=1
- reg_addr  in  3  register offset: 0 src_lo, 1 src_hi, 2 dst_lo, 3 dst_hi, 4 length, 5 ctrl
- reg_din  in  8  register write data
- reg_dout  out  8  register read data (combinational from reg_addr)
- rdy  in  1  bus grant; the FSM advances only when 1 (LCD fetch has priority)
- bus_din  in  8  read data from memory; registered, 1-cycle latency
- bus_addr  out  ADDR_W  shared bus address while busy
- bus_dout  out  8  write data
- bus_we  out  1  write strobe, 1 = write
- busy  out  1  sequencer owns the bus
- irq  out  1  completion interrupt, level
- irq_ack  in  1  one-cycle pulse that clears irq

Behaviour:
- Reset values: all registers 0, state IDLE, busy=0, irq=0, bus_we=0, bus_addr=0, bus_dout=0.
- Register writes (reg_cs & reg_we):
  - Honoured only in IDLE; ignored while busy.
  - Offsets 6–7 are ignored.
- ctrl register:
  - Only bit7 (start) is stored.
  - A write with reg_din[7]=1 in IDLE loads src_cnt={src_hi,src_lo}, dst_cnt={dst_hi,dst_lo} and byte_cnt=length<<BLOCK_SHIFT. length=0 encodes 256, i.e. 4096 bytes, so byte_cnt is 13 bits.
  - The FSM enters RD on the next cycle and busy goes to 1 in that same cycle.
- Register reads:
  - Offsets 0–3 return the live counters, so after completion they read final+1 addresses.
  - Offset 4 returns length.
  - Offset 5 returns {busy, 7'b0}.
  - All other offsets return 0xFF.
- FSM states: IDLE, RD, CAP, WR, DONE. Each non-IDLE state holds while rdy=0; while held, outputs stay stable.
  - RD: bus_addr=src_cnt, bus_we=0 → CAP.
  - CAP: bus_addr=src_cnt, bus_we=0; latch bus_din into the data register → WR.
  - WR: bus_addr=dst_cnt, bus_we=1, bus_dout=data; src_cnt+1, dst_cnt+1 (both wrap modulo 2^ADDR_W); byte_cnt−1. Go to DONE if byte_cnt was 1, else RD.
  - DONE: busy=0, irq set, ctrl bit7 cleared → IDLE. DONE lasts one cycle and ignores rdy.
- Throughput: 3 granted cycles per byte. A 16-byte job with rdy=1 runs 48 cycles of busy, then the DONE cycle.
- Bus outputs: bus_we is 1 only in WR with rdy=1. In IDLE and DONE, bus_addr, bus_dout and bus_we hold their reset values.
- irq:
  - Set in DONE.
  - Cleared by irq_ack.
  - If set and ack occur in the same cycle, set wins.
  - Starting a new job does not clear irq.
- Reset mid-transfer: immediately returns to IDLE with busy=0 and no further bus writes; the register file clears.

Test Plan:
- Basic copy:
  - Stimulus: src=0x0100, dst=0x4000, length=1, ctrl=0x80, rdy=1, memory model with 1-cycle read latency.
  - Required: 16 bytes copied in order; busy high for exactly 48 cycles; irq rises in DONE; offsets 0/1 read 0x10/0x01 and 2/3 read 0x10/0x40.
- Grant stall:
  - Stimulus: same job with rdy toggled pseudo-randomly.
  - Required: identical memory result; no bus_we while rdy=0; bus_addr stable across stalls.
- Maximum length and wrap:
  - Stimulus: length=0, src=0xFFF8.
  - Required: 4096 bytes moved; src counter wraps 0xFFFF→0x0000; final src reads 0x0FF8.
- Busy lockout:
  - Stimulus: during a transfer, write dst_lo=0xAA and ctrl=0x80.
  - Required: both ignored; transfer completes unchanged; ctrl reads 0x80 while busy and 0x00 after.
- IRQ handshake:
  - Stimulus: irq_ack asserted in the same cycle as DONE.
  - Required: irq=1 afterwards. A later irq_ack pulse → irq=0.
- Reset mid-copy:
  - Stimulus: assert reset after 5 bytes.
  - Required: next cycle busy=0, bus_we=0, all registers read 0, irq=0; exactly 5 destination bytes written.
